// File: rtl/iter_mag_comparator_if.sv
// Operand/handshake/result bundle for the iterative magnitude comparator.
// The requester drives through master; the comparator core sits on slave.
interface iter_mag_comparator_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic             agtb;
  logic             altb;
  logic             aeqb;

  modport master (
    output start, signed_mode, a, b,
    input  ready, done, agtb, altb, aeqb
  );

  modport slave (
    input  start, signed_mode, a, b,
    output ready, done, agtb, altb, aeqb
  );
endinterface

// File: rtl/iter_mag_comparator.sv
// Iterative MSB-first magnitude comparator: DIGIT bits per clock, early exit on
// the first differing digit, unsigned or two's complement operands.
module iter_mag_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  iter_mag_comparator_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("iter_mag_comparator: illegal WIDTH/DIGIT combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             agtb_q, agtb_d;
  logic             altb_q, altb_d;
  logic             aeqb_q, aeqb_d;

  logic [DIGIT-1:0] top_a_s;
  logic [DIGIT-1:0] top_b_s;

  assign top_a_s = a_q[WIDTH-1 -: DIGIT];
  assign top_b_s = b_q[WIDTH-1 -: DIGIT];

  // Next-state logic: load, digit-serial compare with early exit, result hold
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    agtb_d  = agtb_q;
    altb_d  = altb_q;
    aeqb_d  = aeqb_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // Flipping both MSBs maps two's complement onto offset binary,
          // so the unsigned digit compare below serves both modes.
          if (bus.signed_mode) begin
            a_d = bus.a ^ MSB_MASK;
            b_d = bus.b ^ MSB_MASK;
          end else begin
            a_d = bus.a;
            b_d = bus.b;
          end
          cnt_d   = {CW{1'b0}};
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (top_a_s != top_b_s) begin
          agtb_d  = (top_a_s > top_b_s);
          altb_d  = (top_a_s < top_b_s);
          aeqb_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == CW'(N - 1)) begin
          agtb_d  = 1'b0;
          altb_d  = 1'b0;
          aeqb_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          a_d   = a_q << DIGIT;
          b_d   = b_q << DIGIT;
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset abandons any operation in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      done_q  <= 1'b0;
      agtb_q  <= 1'b0;
      altb_q  <= 1'b0;
      aeqb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      agtb_q  <= agtb_d;
      altb_q  <= altb_d;
      aeqb_q  <= aeqb_d;
    end
  end

  assign bus.ready = (state_q == S_IDLE);
  assign bus.done  = done_q;
  assign bus.agtb  = agtb_q;
  assign bus.altb  = altb_q;
  assign bus.aeqb  = aeqb_q;

endmodule

// File: tb/tb_iter_mag_comparator.sv
// Randomized self-checking bench for iter_mag_comparator against a
// cycle-level reference model derived from operand arithmetic.
module tb_iter_mag_comparator;

  localparam int W = 16;
  localparam int D = 2;
  localparam int N = W / D;
  localparam logic [W-1:0] DMASK = W'((1 << D) - 1);

  logic clk;
  logic reset_n;

  iter_mag_comparator_if #(.WIDTH(W)) bus ();

  iter_mag_comparator #(.WIDTH(W), .DIGIT(D)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycles to decision: 1-based index of the first differing DIGIT-bit group, N if equal
  function automatic int ref_k(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] d;
    d = x ^ y;
    for (int i = 0; i < N; i++) begin
      if (((d >> (W - (i + 1) * D)) & DMASK) != '0) return i + 1;
    end
    return N;
  endfunction

  // 0 = equal, 1 = a>b, 2 = a<b
  function automatic int ref_code(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    if (s) begin
      if ($signed(x) > $signed(y)) return 1;
      if ($signed(x) < $signed(y)) return 2;
      return 0;
    end else begin
      if (x > y) return 1;
      if (x < y) return 2;
      return 0;
    end
  endfunction

  function automatic logic [2:0] code_flags(input int c);
    if (c == 1) return 3'b100;
    if (c == 2) return 3'b010;
    return 3'b001;
  endfunction

  // Reference model: 0 idle, 1 deciding (m_rem edges to go), 2 done cycle
  int         m_phase = 0;
  int         m_rem   = 0;
  int         m_code  = 0;
  logic       e_done  = 1'b0;
  logic [2:0] e_flags = 3'b000;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= 0;
      m_rem   <= 0;
      e_done  <= 1'b0;
      e_flags <= 3'b000;
    end else begin
      e_done <= 1'b0;
      case (m_phase)
        0: if (bus.start) begin
             m_rem   <= ref_k(bus.a, bus.b);
             m_code  <= ref_code(bus.a, bus.b, bus.signed_mode);
             m_phase <= 1;
           end
        1: begin
             m_rem <= m_rem - 1;
             if (m_rem == 1) begin
               e_done  <= 1'b1;
               e_flags <= code_flags(m_code);
               m_phase <= 2;
             end
           end
        default: m_phase <= 0;
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("ready", 32'(bus.ready), 32'(m_phase == 0));
    chk("done",  32'(bus.done),  32'(e_done));
    chk("flags", 32'({bus.agtb, bus.altb, bus.aeqb}), 32'(e_flags));
  end

  task automatic wait_ready(input string name);
    int g;
    g = 0;
    @(negedge clk);
    while (!bus.ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!bus.ready) chk({name, "_ready_timeout"}, 32'(bus.ready), 32'd1);
  endtask

  // One directed operation with literal latency and flag expectations
  task automatic run_dir(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic s, input int k, input logic [2:0] flg, input bit pulse);
    int  lat;
    bit  seen;
    logic [31:0] r;
    chk({name, "_model_k"},    32'(ref_k(xa, xb)), 32'(k));
    chk({name, "_model_flag"}, 32'(code_flags(ref_code(xa, xb, s))), 32'(flg));
    wait_ready(name);
    bus.start = 1'b1; bus.a = xa; bus.b = xb; bus.signed_mode = s;
    @(posedge clk);
    #1;
    r = $urandom;
    bus.start = 1'b0; bus.a = r[15:0]; bus.b = r[31:16]; bus.signed_mode = ~s;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (pulse && lat == 2) begin
        bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'h0000;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    chk({name, "_latency"}, 32'(lat), 32'(k));
    chk({name, "_flags"}, 32'({bus.agtb, bus.altb, bus.aeqb}), 32'(flg));
    @(negedge clk);
    chk({name, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] r2;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.signed_mode = 1'b0; bus.a = '0; bus.b = '0;
    #2;
    chk("reset_ready", 32'(bus.ready), 32'd1);
    chk("reset_flags", 32'({bus.done, bus.agtb, bus.altb, bus.aeqb}), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    run_dir("u_8000_7fff", 16'h8000, 16'h7FFF, 1'b0, 1, 3'b100, 1'b0);
    run_dir("s_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, 1, 3'b010, 1'b0);
    run_dir("s_ffff_0000", 16'hFFFF, 16'h0000, 1'b1, 1, 3'b010, 1'b0);
    run_dir("u_ffff_0000", 16'hFFFF, 16'h0000, 1'b0, 1, 3'b100, 1'b0);
    run_dir("u_eq_1234",   16'h1234, 16'h1234, 1'b0, 8, 3'b001, 1'b0);
    run_dir("s_eq_1234",   16'h1234, 16'h1234, 1'b1, 8, 3'b001, 1'b0);
    run_dir("u_0003_0002", 16'h0003, 16'h0002, 1'b0, 8, 3'b100, 1'b0);
    run_dir("u_0400_0800", 16'h0400, 16'h0800, 1'b0, 3, 3'b010, 1'b0);
    run_dir("eq_ignore",   16'h1234, 16'h1234, 1'b0, 8, 3'b001, 1'b1);
    run_dir("u_zero",      16'h0000, 16'h0000, 1'b0, 8, 3'b001, 1'b0);

    // Reset during RUN: operation abandoned, no done afterwards
    wait_ready("rst_mid");
    bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h1234; bus.signed_mode = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(bus.ready), 32'd1);
    chk("rst_mid_outs",  32'({bus.done, bus.agtb, bus.altb, bus.aeqb}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_mid_no_done", 32'(bus.done), 32'd0);
    end

    // start held high: each op accepted on its first ready edge
    bus.start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (bus.ready) begin
        r = $urandom; r2 = $urandom;
        bus.a = r[15:0];
        bus.b = r2[0] ? r[15:0] : r[31:16];
        bus.signed_mode = r2[1];
      end
      @(negedge clk);
    end

    // Random traffic with biased near-equal operands and random start
    for (int i = 0; i < 30000; i++) begin
      r = $urandom; r2 = $urandom;
      bus.start = (r2[1:0] != 2'b00);
      bus.signed_mode = r2[2];
      bus.a = r[15:0];
      case (r2[4:3])
        2'd0:    bus.b = r[15:0];
        2'd1:    bus.b = r[15:0] ^ (16'h0001 << r2[8:5]);
        2'd2:    bus.b = r[31:16];
        default: bus.b = {r[15:4], r[19:16]};
      endcase
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
